// File: rtl/dsp_systolic_accum_pkg.sv
// Shared types, default widths and the accumulator add helper for dsp_systolic_accum.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: accum_state_t, DEF_* width defaults, MAX_ACC_WIDTH, sat_add().
package dsp_systolic_accum_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accum_state_t;

  localparam int DEF_RESULT_A_WIDTH = 64;
  localparam int DEF_ACC_WIDTH      = 80;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int DEF_SATURATE       = 1;

  // Widest accumulator sat_add can serve; operands are zero-extended to this.
  localparam int MAX_ACC_WIDTH = 128;

  // Adds two values that fit in 'width' bits. Result bits [width-1:0] hold the
  // clamped (saturate=1) or wrapped (saturate=0) sum; bit MAX_ACC_WIDTH holds the
  // carry out of 'width' bits. Bits in between are always zero.
  function automatic logic [MAX_ACC_WIDTH:0] sat_add(
    input logic [MAX_ACC_WIDTH-1:0] a,
    input logic [MAX_ACC_WIDTH-1:0] b,
    input int unsigned              width,
    input logic                     saturate
  );
    logic [MAX_ACC_WIDTH:0] one;
    logic [MAX_ACC_WIDTH:0] mask;
    logic [MAX_ACC_WIDTH:0] sum;
    logic [MAX_ACC_WIDTH:0] res;
    logic                   carry;
    one   = '0;
    one[0] = 1'b1;
    mask  = (one << width) - one;
    sum   = {1'b0, a} + {1'b0, b};
    carry = |(sum & ~mask);
    if (carry) begin
      res = saturate ? mask : (sum & mask);
    end else begin
      res = sum;
    end
    // Relocate the carry to the top bit so callers find it at a fixed place.
    res[MAX_ACC_WIDTH] = carry;
    return res;
  endfunction

endpackage

// File: rtl/dsp_accum_out_buf.sv
// Two-entry FIFO holding completed frame records for the accumulator output.
// Latency: a pushed record is visible on dout/!empty after the push edge; dout is a register read.
// Backpressure: push is ignored when full unless a pop happens in the same cycle (pop before push).
// Ports: clk, rst (async, active-high), push/din (write), pop (read), full, empty, dout (head entry).
module dsp_accum_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // When full, the slot being freed by the pop is exactly the one wr_ptr names.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsp_systolic_accum.sv
// Frame accumulator: sums chain result words over in_last-delimited frames, emits total/count/ovf.
// Latency: record is valid the cycle after the last beat's edge (empty buffer); one beat per cycle sustained.
// Backpressure: 2-entry output buffer; input cannot stall, so a frame finding the buffer full is dropped (sticky drop).
// Ports: clk, rst (async, active-high); in_valid/in_last/in_data beat input;
//        out_valid/out_ready/out_data/out_count/out_ovf record output; busy (frame open), drop (sticky discard flag).
module dsp_systolic_accum
  import dsp_systolic_accum_pkg::*;
#(
  parameter int RESULT_A_WIDTH = DEF_RESULT_A_WIDTH,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int SATURATE       = DEF_SATURATE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [RESULT_A_WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [CNT_WIDTH-1:0]      out_count,
  output logic                      out_ovf,
  output logic                      busy,
  output logic                      drop
);

  localparam int REC_WIDTH = ACC_WIDTH + CNT_WIDTH + 1;

  accum_state_t           state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   acc_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   ovf;
  logic                   ovf_nxt;
  logic                   first_beat;
  logic [MAX_ACC_WIDTH:0] add_res;
  logic                   carry;
  logic                   unused_add_hi;
  logic                   frame_done;
  logic                   buf_full;
  logic                   buf_empty;
  logic                   buf_pop;
  logic                   buf_push;
  logic [REC_WIDTH-1:0]   rec_in;
  logic [REC_WIDTH-1:0]   rec_out;

  // In IDLE the incoming beat opens a new frame and replaces the stale acc.
  assign first_beat = (state == IDLE);

  assign add_res = sat_add(MAX_ACC_WIDTH'(acc), MAX_ACC_WIDTH'(in_data),
                           ACC_WIDTH, SATURATE != 0);
  assign carry   = add_res[MAX_ACC_WIDTH];
  // Bits between ACC_WIDTH and the carry are zero by construction.
  assign unused_add_hi = |(add_res[MAX_ACC_WIDTH-1:0] >> ACC_WIDTH);

  always_comb begin
    acc_nxt = add_res[ACC_WIDTH-1:0];
    cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
    ovf_nxt = ovf | carry;
    if (first_beat) begin
      acc_nxt = ACC_WIDTH'(in_data);
      cnt_nxt = CNT_WIDTH'(1);
      ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (in_valid) begin
      state <= in_last ? IDLE : ACCUM;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign frame_done = in_valid && in_last;
  assign buf_pop    = !buf_empty && out_ready;
  assign buf_push   = frame_done && (!buf_full || buf_pop);
  assign rec_in     = {acc_nxt, cnt_nxt, ovf_nxt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (frame_done && buf_full && !buf_pop) begin
      drop <= 1'b1;
    end
  end

  dsp_accum_out_buf #(
    .WIDTH (REC_WIDTH)
  ) u_out_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .din   (rec_in),
    .pop   (buf_pop),
    .full  (buf_full),
    .empty (buf_empty),
    .dout  (rec_out)
  );

  assign out_valid = !buf_empty;
  assign out_data  = rec_out[REC_WIDTH-1 -: ACC_WIDTH];
  assign out_count = rec_out[CNT_WIDTH:1];
  assign out_ovf   = rec_out[0];
  assign busy      = (state == ACCUM);

endmodule

// File: tb/tb_dsp_systolic_accum.sv
// Bench for dsp_systolic_accum: three instances (80-bit saturating, 8-bit saturating, 8-bit wrapping).
// A frame-level model (true sums, queue of records) is compared every cycle; directed cases pin literals.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_dsp_systolic_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        o0_valid, o0_ovf, o0_busy, o0_drop;
  logic [79:0] o0_data;
  logic [15:0] o0_count;
  logic        o1_valid, o1_ovf, o1_busy, o1_drop;
  logic [7:0]  o1_data;
  logic [3:0]  o1_count;
  logic        o2_valid, o2_ovf, o2_busy, o2_drop;
  logic [7:0]  o2_data;
  logic [3:0]  o2_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_systolic_accum dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .out_valid(o0_valid), .out_ready(out_ready), .out_data(o0_data), .out_count(o0_count),
    .out_ovf(o0_ovf), .busy(o0_busy), .drop(o0_drop));

  dsp_systolic_accum #(.RESULT_A_WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data[7:0]),
    .out_valid(o1_valid), .out_ready(out_ready), .out_data(o1_data), .out_count(o1_count),
    .out_ovf(o1_ovf), .busy(o1_busy), .drop(o1_drop));

  dsp_systolic_accum #(.RESULT_A_WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(4), .SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data[7:0]),
    .out_valid(o2_valid), .out_ready(out_ready), .out_data(o2_data), .out_count(o2_count),
    .out_ovf(o2_ovf), .busy(o2_busy), .drop(o2_drop));

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0][127:0] data;
    logic [2:0][31:0]  count;
    logic [2:0]        ovf;
  } rec_t;

  rec_t         mq[$];
  rec_t         mrec;
  logic [127:0] msum [3];
  int           mn = 0;
  bit           mopen = 0;
  bit           mdrop = 0;
  bit           mpop, mpush;

  function automatic logic [127:0] lim(input int bits);
    return (128'd1 << bits) - 128'd1;
  endfunction

  function automatic int acc_w(input int k);
    return (k == 0) ? 80 : 8;
  endfunction

  function automatic int cnt_w(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int in_w(input int k);
    return (k == 0) ? 64 : 8;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mopen = 0;
      mdrop = 0;
      mn    = 0;
    end else begin
      mpop  = (mq.size() != 0) && out_ready;
      mpush = 0;
      if (in_valid) begin
        mn = mopen ? mn + 1 : 1;
        for (int k = 0; k < 3; k++) begin
          msum[k] = (mopen ? msum[k] : 128'd0) + ({64'd0, in_data} & lim(in_w(k)));
        end
        if (in_last) begin
          for (int k = 0; k < 3; k++) begin
            // Frame total from the exact sum: clamp or wrap once it exceeds the width.
            mrec.ovf[k]   = msum[k] > lim(acc_w(k));
            mrec.data[k]  = !mrec.ovf[k] ? msum[k] :
                            (k != 2) ? lim(acc_w(k)) : (msum[k] & lim(acc_w(k)));
            mrec.count[k] = (128'(mn) > lim(cnt_w(k))) ? 32'(lim(cnt_w(k))) : 32'(mn);
          end
          mpush = 1;
          mopen = 0;
        end else begin
          mopen = 1;
        end
      end
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        if (mq.size() < 2) mq.push_back(mrec);
        else mdrop = 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic v, input logic [127:0] d, input logic [31:0] c,
                     input logic o, input logic b, input logic dr);
    chk($sformatf("d%0d.out_valid", k), 128'(v), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk($sformatf("d%0d.out_data", k), d, mq[0].data[k]);
      chk($sformatf("d%0d.out_count", k), 128'(c), 128'(mq[0].count[k]));
      chk($sformatf("d%0d.out_ovf", k), 128'(o), 128'(mq[0].ovf[k]));
    end
    chk($sformatf("d%0d.busy", k), 128'(b), 128'(mopen));
    chk($sformatf("d%0d.drop", k), 128'(dr), 128'(mdrop));
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      cmp(0, o0_valid, 128'(o0_data), 32'(o0_count), o0_ovf, o0_busy, o0_drop);
      cmp(1, o1_valid, 128'(o1_data), 32'(o1_count), o1_ovf, o1_busy, o1_drop);
      cmp(2, o2_valid, 128'(o2_data), 32'(o2_count), o2_ovf, o2_busy, o2_drop);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic v, input logic l, input logic [63:0] d, input logic r);
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"}, 128'(o0_valid), 128'd0);
    chk({tag, ".out_data"},  128'(o0_data),  128'd0);
    chk({tag, ".out_count"}, 128'(o0_count), 128'd0);
    chk({tag, ".out_ovf"},   128'(o0_ovf),   128'd0);
    chk({tag, ".busy"},      128'(o0_busy),  128'd0);
    chk({tag, ".drop"},      128'(o0_drop),  128'd0);
  endtask

  task automatic pulse_rst();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Single-beat frame.
    tick(1, 1, 64'd5, 1);
    chk("single.out_valid", 128'(o0_valid), 128'd1);
    chk("single.out_data",  128'(o0_data),  128'd5);
    chk("single.out_count", 128'(o0_count), 128'd1);
    chk("single.out_ovf",   128'(o0_ovf),   128'd0);
    tick(0, 0, 64'd0, 1);
    chk("single.one_cycle", 128'(o0_valid), 128'd0);

    // Four beats with a gap.
    tick(1, 0, 64'd100, 1);
    chk("gap.busy_open", 128'(o0_busy), 128'd1);
    tick(1, 0, 64'd200, 1);
    tick(0, 0, 64'd0, 1);
    chk("gap.busy_gap", 128'(o0_busy), 128'd1);
    tick(1, 0, 64'd300, 1);
    tick(1, 1, 64'd400, 1);
    chk("gap.busy_closed", 128'(o0_busy),  128'd0);
    chk("gap.out_data",    128'(o0_data),  128'd1000);
    chk("gap.out_count",   128'(o0_count), 128'd4);
    tick(0, 0, 64'd0, 1);

    // 8-bit overflow: saturate vs wrap.
    tick(1, 0, 64'd200, 1);
    tick(1, 1, 64'd100, 1);
    chk("ovf.sat_data", 128'(o1_data), 128'd255);
    chk("ovf.sat_ovf",  128'(o1_ovf),  128'd1);
    chk("ovf.wrap_data", 128'(o2_data), 128'd44);
    chk("ovf.wrap_ovf",  128'(o2_ovf),  128'd1);
    chk("ovf.wide_data", 128'(o0_data), 128'd300);
    tick(0, 0, 64'd0, 1);

    // Backpressure: third frame is dropped.
    tick(1, 1, 64'd1, 0);
    tick(1, 1, 64'd2, 0);
    tick(1, 1, 64'd3, 0);
    chk("bp.drop", 128'(o0_drop), 128'd1);
    chk("bp.head", 128'(o0_data), 128'd1);
    tick(0, 0, 64'd0, 1);
    chk("bp.second", 128'(o0_data), 128'd2);
    tick(0, 0, 64'd0, 1);
    chk("bp.no_third", 128'(o0_valid), 128'd0);

    // Reset in the middle of a frame.
    tick(1, 0, 64'd7, 1);
    tick(1, 0, 64'd8, 1);
    pulse_rst();
    check_zero("midrst");
    tick(1, 1, 64'd9, 1);
    chk("midrst.out_data",  128'(o0_data),  128'd9);
    chk("midrst.out_count", 128'(o0_count), 128'd1);
    tick(0, 0, 64'd0, 1);

    // Full buffer with a pop in the same cycle as the push.
    tick(1, 1, 64'd1, 0);
    tick(1, 1, 64'd2, 0);
    chk("fullpop.head", 128'(o0_data), 128'd1);
    tick(1, 1, 64'd7, 1);
    chk("fullpop.drop", 128'(o0_drop), 128'd0);
    chk("fullpop.second", 128'(o0_data), 128'd2);
    tick(0, 0, 64'd0, 1);
    chk("fullpop.third", 128'(o0_data), 128'd7);
    tick(0, 0, 64'd0, 1);
    chk("fullpop.empty", 128'(o0_valid), 128'd0);

    // Random traffic against the model.
    pulse_rst();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 70, $urandom_range(0, 7) == 0,
           {$urandom(), $urandom()}, $urandom_range(0, 9) != 0);
    end
    repeat (4) tick(0, 0, 64'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
